// File: rtl/cnt_rr_sched.sv
// Round-robin scheduler sharing one counter register between N_REQ requesters.
// Each grant latches the winner's opcode/data, applies it in EXEC and pulses ack.
module cnt_rr_sched #(
    parameter int N_REQ = 3,
    parameter int DW    = 8
) (
    input  logic                  clk1,
    input  logic                  rstn,
    input  logic [N_REQ-1:0]      req,
    input  logic [2*N_REQ-1:0]    op,
    input  logic [DW*N_REQ-1:0]   wdata,
    output logic [N_REQ-1:0]      gnt,
    output logic [N_REQ-1:0]      ack,
    output logic [DW-1:0]         cnt_q,
    output logic                  wrap,
    output logic                  busy,
    output logic                  dbg_state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] OP_INC   = 2'b00;
    localparam logic [1:0] OP_DEC   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t            state, state_d;
    logic [IW-1:0]     ptr, ptr_d;
    logic [IW-1:0]     win, win_d;
    logic [IW-1:0]     pick;
    logic              found;
    logic [1:0]        op_l, op_d;
    logic [DW-1:0]     wdata_l, wdata_d;
    logic [DW-1:0]     cnt_d;
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  gnt_d, ack_d;
    logic              wrap_d;

    // A requester being acked this cycle is masked so a stale level cannot re-win.
    assign elig = req & ~ack;

    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx  = (int'(ptr) + k) % N_REQ;
            cand = IW'(idx);
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        win_d   = win;
        op_d    = op_l;
        wdata_d = wdata_l;
        cnt_d   = cnt_q;
        gnt_d   = gnt;
        ack_d   = '0;
        wrap_d  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    win_d   = pick;
                    op_d    = op[2*int'(pick) +: 2];
                    wdata_d = wdata[DW*int'(pick) +: DW];
                    gnt_d   = N_REQ'(1) << pick;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                case (op_l)
                    OP_INC: begin
                        cnt_d  = cnt_q + DW'(1);
                        wrap_d = &cnt_q;
                    end
                    OP_DEC: begin
                        cnt_d  = cnt_q - DW'(1);
                        wrap_d = ~|cnt_q;
                    end
                    OP_LOAD:  cnt_d = wdata_l;
                    OP_CLEAR: cnt_d = '0;
                    default:  cnt_d = cnt_q;
                endcase
                gnt_d   = '0;
                ack_d   = N_REQ'(1) << win;
                ptr_d   = (int'(win) == N_REQ - 1) ? '0 : win + IW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            ptr     <= '0;
            win     <= '0;
            op_l    <= OP_INC;
            wdata_l <= '0;
            cnt_q   <= '0;
            gnt     <= '0;
            ack     <= '0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            win     <= win_d;
            op_l    <= op_d;
            wdata_l <= wdata_d;
            cnt_q   <= cnt_d;
            gnt     <= gnt_d;
            ack     <= ack_d;
            wrap    <= wrap_d;
        end
    end

    assign busy      = (state == EXEC);
    assign dbg_state = state;

endmodule
